// File: rtl/mem_access_stage.sv
// Memory-access stage: turns the ALU result into a writeback value or a data-bus
// load/store, with misaligned, illegal-op and bus-timeout exceptions.
module mem_access_stage #(
  parameter int MAX_WAIT  = 255,
  parameter int CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_dest,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_addr
);

  typedef enum logic { ST_IDLE = 1'b0, ST_BUSY = 1'b1 } state_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_LB   = 3'd2;
  localparam logic [2:0] OP_LBU  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_SB   = 3'd5;

  localparam logic [1:0] EXC_MISALIGN = 2'd0;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd1;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] WAIT_LIMIT = CNT_WIDTH'(MAX_WAIT);

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [1:0]           lane_q, lane_d;
  logic [4:0]           dest_q, dest_d;
  logic [31:0]          addr_q, addr_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [31:0]          bus_addr_q, bus_addr_d;
  logic [3:0]           bus_be_q, bus_be_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic [4:0]           wb_dest_q, wb_dest_d;
  logic                 exc_valid_q, exc_valid_d;
  logic [1:0]           exc_code_q, exc_code_d;
  logic [31:0]          exc_addr_q, exc_addr_d;
  logic                 start_s;
  logic [7:0]           rbyte_s;

  // Next-state and next-output computation for both states.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lane_d      = lane_q;
    dest_d      = dest_q;
    addr_d      = addr_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_dest_d   = wb_dest_q;
    exc_valid_d = 1'b0;
    exc_code_d  = exc_code_q;
    exc_addr_d  = exc_addr_q;
    start_s     = 1'b0;
    rbyte_s     = lane_byte(bus_rdata, lane_q);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          case (in_op)
            OP_NONE: begin
              wb_valid_d = 1'b1;
              wb_data_d  = in_alu_result;
              wb_dest_d  = in_dest;
            end
            OP_LW, OP_SW: begin
              if (in_alu_result[1:0] != 2'b00) begin
                exc_valid_d = 1'b1;
                exc_code_d  = EXC_MISALIGN;
                exc_addr_d  = in_alu_result;
              end else begin
                start_s = 1'b1;
              end
            end
            OP_LB, OP_LBU, OP_SB: start_s = 1'b1;
            default: begin
              exc_valid_d = 1'b1;
              exc_code_d  = EXC_ILLEGAL;
              exc_addr_d  = in_alu_result;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end

        if (start_s) begin
          state_d    = ST_BUSY;
          cnt_d      = {CNT_WIDTH{1'b0}};
          op_d       = in_op;
          lane_d     = in_alu_result[1:0];
          dest_d     = in_dest;
          addr_d     = in_alu_result;
          bus_req_d  = 1'b1;
          bus_we_d   = (in_op == OP_SW) || (in_op == OP_SB);
          bus_addr_d = {in_alu_result[31:2], 2'b00};
          case (in_op)
            OP_LW:   begin bus_be_d = 4'b1111; bus_wdata_d = 32'h0000_0000; end
            OP_SW:   begin bus_be_d = 4'b1111; bus_wdata_d = in_store_data; end
            OP_SB:   begin bus_be_d = 4'b0001 << in_alu_result[1:0]; bus_wdata_d = {4{in_store_data[7:0]}}; end
            default: begin bus_be_d = 4'b0001 << in_alu_result[1:0]; bus_wdata_d = 32'h0000_0000; end
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_BUSY: begin
        // Ack has priority over the wait limit when both land on the same cycle.
        if (bus_ack) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          case (op_q)
            OP_LW:   begin wb_valid_d = 1'b1; wb_dest_d = dest_q; wb_data_d = bus_rdata; end
            OP_LB:   begin wb_valid_d = 1'b1; wb_dest_d = dest_q; wb_data_d = {{24{rbyte_s[7]}}, rbyte_s}; end
            OP_LBU:  begin wb_valid_d = 1'b1; wb_dest_d = dest_q; wb_data_d = {24'h00_0000, rbyte_s}; end
            default: wb_valid_d = 1'b0;
          endcase
        end else if (cnt_q == WAIT_LIMIT) begin
          state_d     = ST_IDLE;
          bus_req_d   = 1'b0;
          exc_valid_d = 1'b1;
          exc_code_d  = EXC_TIMEOUT;
          exc_addr_d  = addr_q;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears the bus request without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_WIDTH{1'b0}};
      op_q        <= 3'd0;
      lane_q      <= 2'd0;
      dest_q      <= 5'd0;
      addr_q      <= 32'h0000_0000;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= 32'h0000_0000;
      wb_dest_q   <= 5'd0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= 2'd0;
      exc_addr_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      dest_q      <= dest_d;
      addr_q      <= addr_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign stall     = (state_q == ST_BUSY);
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_dest   = wb_dest_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;
  assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with MAX_WAIT=4 and hand-computed expectations.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_dest;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic [31:0] exc_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_stage #(.MAX_WAIT(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_dest(in_dest),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d);
    in_valid      = 1'b1;
    in_op         = op;
    in_alu_result = a;
    in_store_data = sd;
    in_dest       = d;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_alu_result = 32'h0;
    in_store_data = 32'h0; in_dest = 5'd0; bus_rdata = 32'h0; bus_ack = 1'b0;
    #12;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // NONE passthrough and back-to-back
    issue(3'd0, 32'h1234_5678, 32'h0, 5'd3);
    tick();
    chk("none_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("none_wb_data", wb_data, 32'h1234_5678);
    chk("none_wb_dest", {27'd0, wb_dest}, 32'd3);
    chk("none_stall", {31'd0, stall}, 32'd0);
    issue(3'd0, 32'h0000_0011, 32'h0, 5'd4);
    tick();
    chk("b2b1_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b1_data", wb_data, 32'h0000_0011);
    issue(3'd0, 32'h0000_0022, 32'h0, 5'd5);
    tick();
    chk("b2b2_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b2_data", wb_data, 32'h0000_0022);
    issue(3'd0, 32'h0000_0033, 32'h0, 5'd6);
    tick();
    chk("b2b3_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b3_dest", {27'd0, wb_dest}, 32'd6);
    in_valid = 1'b0;
    tick();
    chk("none_pulse_end", {31'd0, wb_valid}, 32'd0);
    chk("none_hold_data", wb_data, 32'h0000_0033);

    // LB, sign-extended lane 2
    issue(3'd2, 32'h0000_1002, 32'h0, 5'd10);
    tick();
    in_valid = 1'b0;
    chk("lb_stall", {31'd0, stall}, 32'd1);
    chk("lb_req", {31'd0, bus_req}, 32'd1);
    chk("lb_addr", bus_addr, 32'h0000_1000);
    chk("lb_be", {28'd0, bus_be}, 32'h4);
    chk("lb_we", {31'd0, bus_we}, 32'd0);
    chk("lb_wdata", bus_wdata, 32'd0);
    tick();
    chk("lb_wait_stall", {31'd0, stall}, 32'd1);
    chk("lb_wait_addr", bus_addr, 32'h0000_1000);
    bus_ack = 1'b1; bus_rdata = 32'h00F0_0000;
    tick();
    bus_ack = 1'b0;
    chk("lb_done_req", {31'd0, bus_req}, 32'd0);
    chk("lb_done_stall", {31'd0, stall}, 32'd0);
    chk("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lb_wb_data", wb_data, 32'hFFFF_FFF0);
    chk("lb_wb_dest", {27'd0, wb_dest}, 32'd10);

    // LBU, same lane, zero-extended
    issue(3'd3, 32'h0000_1002, 32'h0, 5'd11);
    tick();
    in_valid = 1'b0;
    chk("lbu_be", {28'd0, bus_be}, 32'h4);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h00F0_0000;
    tick();
    bus_ack = 1'b0;
    chk("lbu_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lbu_wb_data", wb_data, 32'h0000_00F0);
    chk("lbu_wb_dest", {27'd0, wb_dest}, 32'd11);

    // SB lane 3
    issue(3'd5, 32'h0000_0013, 32'hAABB_CCDD, 5'd12);
    tick();
    in_valid = 1'b0;
    chk("sb_we", {31'd0, bus_we}, 32'd1);
    chk("sb_be", {28'd0, bus_be}, 32'h8);
    chk("sb_wdata", bus_wdata, 32'hDDDD_DDDD);
    chk("sb_addr", bus_addr, 32'h0000_0010);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("sb_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("sb_req_drop", {31'd0, bus_req}, 32'd0);

    // SW full word
    issue(3'd4, 32'h0000_0020, 32'h1122_3344, 5'd1);
    tick();
    in_valid = 1'b0;
    chk("sw_be", {28'd0, bus_be}, 32'hF);
    chk("sw_wdata", bus_wdata, 32'h1122_3344);
    chk("sw_we", {31'd0, bus_we}, 32'd1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("sw_no_wb", {31'd0, wb_valid}, 32'd0);

    // Misaligned LW and illegal opcode
    issue(3'd1, 32'h0000_0006, 32'h0, 5'd2);
    tick();
    chk("mis_exc_valid", {31'd0, exc_valid}, 32'd1);
    chk("mis_exc_code", {30'd0, exc_code}, 32'd0);
    chk("mis_exc_addr", exc_addr, 32'h0000_0006);
    chk("mis_no_req", {31'd0, bus_req}, 32'd0);
    chk("mis_no_wb", {31'd0, wb_valid}, 32'd0);
    issue(3'd7, 32'hDEAD_0001, 32'h0, 5'd2);
    tick();
    in_valid = 1'b0;
    chk("ill_exc_valid", {31'd0, exc_valid}, 32'd1);
    chk("ill_exc_code", {30'd0, exc_code}, 32'd2);
    chk("ill_exc_addr", exc_addr, 32'hDEAD_0001);
    chk("ill_no_req", {31'd0, bus_req}, 32'd0);
    tick();
    chk("exc_pulse_end", {31'd0, exc_valid}, 32'd0);

    // Ack while idle is ignored
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("idle_ack_wb", {31'd0, wb_valid}, 32'd0);
    chk("idle_ack_req", {31'd0, bus_req}, 32'd0);

    // Timeout: counter 0..3 increments, limit reached on the fifth BUSY cycle
    issue(3'd1, 32'h0000_0040, 32'h0, 5'd7);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", {31'd0, bus_req}, 32'd1);
      tick();
    end
    chk("to_req_last", {31'd0, bus_req}, 32'd1);
    tick();
    chk("to_req_drop", {31'd0, bus_req}, 32'd0);
    chk("to_stall", {31'd0, stall}, 32'd0);
    chk("to_exc_valid", {31'd0, exc_valid}, 32'd1);
    chk("to_exc_code", {30'd0, exc_code}, 32'd1);
    chk("to_exc_addr", exc_addr, 32'h0000_0040);
    chk("to_no_wb", {31'd0, wb_valid}, 32'd0);

    // Ack exactly on the limit cycle wins
    issue(3'd1, 32'h0000_0080, 32'h0, 5'd8);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_BABE;
    tick();
    bus_ack = 1'b0;
    chk("lim_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lim_wb_data", wb_data, 32'hCAFE_BABE);
    chk("lim_no_exc", {31'd0, exc_valid}, 32'd0);

    // Asynchronous reset mid-BUSY
    issue(3'd1, 32'h0000_0100, 32'h0, 5'd9);
    tick();
    in_valid = 1'b0;
    chk("ar_req_before", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", {31'd0, bus_req}, 32'd0);
    chk("ar_stall", {31'd0, stall}, 32'd0);
    chk("ar_wb", {31'd0, wb_valid}, 32'd0);
    chk("ar_exc", {31'd0, exc_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    issue(3'd0, 32'h0000_0055, 32'h0, 5'd9);
    tick();
    in_valid = 1'b0;
    chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("post_rst_wb_data", wb_data, 32'h0000_0055);
    chk("post_rst_wb_dest", {27'd0, wb_dest}, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes the ALU result as either the writeback value or the effective address of a load/store.
- Runs a request/acknowledge transaction on the data bus and produces a registered writeback result plus exception flags.
- Stalls the upstream execute stage while a bus transaction is outstanding.

Parameters:
- MAX_WAIT, 255: bus-wait cycles allowed before a bus-error exception (1..65535).
- CNT_WIDTH, 16: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  execute stage presents an instruction
- in_op  input  3  0 NONE, 1 LW, 2 LB, 3 LBU, 4 SW, 5 SB; 6/7 illegal
- in_alu_result  input  32  ALU output: result (NONE) or effective address
- in_store_data  input  32  rt value for stores
- in_dest  input  5  writeback register index
- stall  output  1  upstream must hold its inputs
- bus_req  output  1  data bus request
- bus_we  output  1  1 = write
- bus_addr  output  32  word address, bits [1:0] forced to 0
- bus_be  output  4  byte enables, bit n = byte lane n
- bus_wdata  output  32  write data
- bus_rdata  input  32  read data, valid when bus_ack=1
- bus_ack  input  1  one-cycle transaction completion
- wb_valid  output  1  one-cycle pulse: wb_data/wb_dest valid
- wb_data  output  32  writeback value
- wb_dest  output  5  writeback register index
- exc_valid  output  1  one-cycle exception pulse
- exc_code  output  2  0 misaligned, 1 bus timeout, 2 illegal op
- exc_addr  output  32  offending address (in_alu_result)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; wait counter 0. bus_req drops immediately, including mid-transaction. No wb or exc pulse for an aborted op.
- States: IDLE, BUSY.
- stall = (state == BUSY), combinational, no other term.
- An instruction is accepted on a rising edge with in_valid=1 and state=IDLE.
- Accepted NONE:
  - next cycle wb_valid=1, wb_data=in_alu_result, wb_dest=in_dest.
  - Stays IDLE; back-to-back accepts give one wb pulse per cycle.
- Accepted op 6/7:
  - next cycle exc_valid=1, exc_code=2, exc_addr=in_alu_result.
  - No wb pulse; stays IDLE.
- Accepted LW/SW with address bits [1:0] != 0:
  - next cycle exc_valid=1, exc_code=0, exc_addr=address.
  - No bus request; stays IDLE.
  - LB/LBU/SB are never misaligned.
- Accepted aligned memory op:
  - next cycle state=BUSY, bus_req=1, bus_addr={addr[31:2],2'b00}, bus_we=1 for SW/SB.
  - LW/SW: bus_be=4'b1111. LB/LBU/SB: bus_be=1<<addr[1:0], little-endian lanes.
  - SW: bus_wdata=in_store_data. SB: bus_wdata={4{in_store_data[7:0]}}. Loads: bus_wdata=0.
  - Address, lane and dest are captured at accept; bus outputs stay stable through BUSY.
- BUSY, bus_ack=1 sampled on a rising edge:
  - next cycle bus_req=0, state=IDLE.
  - Loads: wb_valid=1, wb_dest=captured dest.
    - LW: wb_data=bus_rdata.
    - LB: wb_data=bus_rdata byte lane, sign-extended.
    - LBU: wb_data=bus_rdata byte lane, zero-extended.
  - Stores: no wb pulse.
  - Earliest acceptance of the next instruction is the cycle after returning to IDLE, giving one bubble per memory op.
- Wait counter:
  - Cleared on entering BUSY; increments on each BUSY cycle without ack.
  - When it equals MAX_WAIT with no ack: next cycle bus_req=0, state=IDLE, exc_valid=1, exc_code=1, exc_addr=captured full address.
  - If bus_ack and the counter limit occur in the same cycle, ack wins and no exception is raised.
- bus_ack while IDLE is ignored.
- wb_valid and exc_valid are never both 1. Both are single-cycle pulses; wb_data/wb_dest/exc_* hold their last value otherwise.

Test Plan:
- NONE with in_alu_result=0x1234_5678, dest=3 -> next cycle wb_valid=1, wb_data=0x1234_5678, wb_dest=3, stall=0; three back-to-back NONE ops give three consecutive wb pulses.
- LB addr=0x0000_1002, ack after 2 cycles with rdata=0x00F0_0000 -> bus_be=4'b0100, bus_addr=0x0000_1000, stall=1 during BUSY, wb_data=0xFFFF_FFF0. Same with LBU -> wb_data=0x0000_00F0.
- SB addr=0x13, store_data=0xAABB_CCDD -> bus_we=1, bus_be=4'b1000, bus_wdata=0xDDDD_DDDD, bus_addr=0x10; no wb pulse after ack.
- LW addr=0x0000_0006 -> exc_valid=1, exc_code=0, exc_addr=0x6, bus_req never asserted. Opcode 7 -> exc_code=2.
- MAX_WAIT=4, LW with no ack -> bus_req drops after 4 wait cycles, exc_code=1; repeat with ack on the limit cycle -> wb pulse and no exception.
- rst_n=0 asserted mid-BUSY -> bus_req, stall, wb_valid and exc_valid go to 0 immediately without a clock edge; after release, a NONE op completes normally.
